// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared skid-buffer geometry and pointer helper for the FIFO stream reader
package fifo_stream_reader_pkg;

    localparam int SKID_DEPTH = 3;
    localparam int SKID_PW    = 2;

    // Circular pointer increment over SKID_DEPTH entries.
    function automatic logic [SKID_PW-1:0] ptr_inc(input logic [SKID_PW-1:0] p);
        return (p == SKID_PW'(SKID_DEPTH - 1)) ? '0 : p + SKID_PW'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port, output stream and status bundle
interface fifo_stream_reader_if #(
    parameter int W    = 8,
    parameter int CNTW = 16
);
    logic            fifo_empty;
    logic            fifo_r_en;
    logic [W-1:0]    fifo_data;
    logic            flush;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_data;
    logic            m_last;
    logic [CNTW-1:0] stat_words;

    modport master (
        input  fifo_empty, fifo_data, flush, m_ready,
        output fifo_r_en, m_valid, m_data, m_last, stat_words
    );

    modport slave (
        output fifo_empty, fifo_data, flush, m_ready,
        input  fifo_r_en, m_valid, m_data, m_last, stat_words
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// rtl/fifo_stream_reader_skid.sv - 3-entry circular skid buffer holding {last, data} entries
module fifo_stream_reader_skid
    import fifo_stream_reader_pkg::*;
#(
    parameter int EW = 9
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               push,
    input  logic [EW-1:0]      push_entry,
    input  logic               pop,
    output logic [SKID_PW-1:0] occ,
    output logic [EW-1:0]      head_entry
);

    logic [EW-1:0]      mem_q [SKID_DEPTH];
    logic [SKID_PW-1:0] head_q, head_d;
    logic [SKID_PW-1:0] tail_q, tail_d;
    logic [SKID_PW-1:0] occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            case ({push, pop})
                2'b10:   occ_d = occ_q + SKID_PW'(1);
                2'b01:   occ_d = occ_q - SKID_PW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !clear) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    assign occ        = occ_q;
    assign head_entry = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a 1-cycle-latency BRAM FIFO into a framed valid/ready stream
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int W       = 8,
    parameter int PKT_LEN = 16,
    parameter int CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    fifo_stream_reader_if.master bus
);

    localparam int EW  = W + 1;
    localparam int PCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic               infl_q, infl_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [CNTW-1:0]    stat_q, stat_d;
    logic [SKID_PW-1:0] occ;
    logic [EW-1:0]      head_entry;
    logic               rd_en;
    logic               push;
    logic               pop;
    logic               last_in;

    // Issue only from registered state so m_ready never reaches fifo_r_en; occ+infl stays <= 3.
    always_comb begin
        rd_en   = rstn & ~bus.fifo_empty & ~bus.flush
                  & (({1'b0, occ} + {2'b00, infl_q}) <= 3'd2);
        push    = infl_q & ~bus.flush;
        pop     = (occ != '0) & bus.m_ready;
        last_in = (pc_q == PCW'(PKT_LEN - 1));
        infl_d  = rd_en;
        pc_d    = pc_q;
        if (bus.flush)  pc_d = '0;
        else if (push)  pc_d = last_in ? '0 : pc_q + PCW'(1);
        stat_d  = pop ? stat_q + CNTW'(1) : stat_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            infl_q <= 1'b0;
            pc_q   <= '0;
            stat_q <= '0;
        end else begin
            infl_q <= infl_d;
            pc_q   <= pc_d;
            stat_q <= stat_d;
        end
    end

    fifo_stream_reader_skid #(.EW(EW)) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (bus.flush),
        .push       (push),
        .push_entry ({last_in, bus.fifo_data}),
        .pop        (pop),
        .occ        (occ),
        .head_entry (head_entry)
    );

    assign bus.fifo_r_en  = rd_en;
    assign bus.m_valid    = (occ != '0);
    assign bus.m_data     = head_entry[W-1:0];
    assign bus.m_last     = head_entry[W];
    assign bus.stat_words = stat_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.W(8), .CNTW(16)) bus1 ();
    fifo_stream_reader_if #(.W(8), .CNTW(4))  bus2 ();

    fifo_stream_reader #(.W(8), .PKT_LEN(16), .CNTW(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    fifo_stream_reader #(.W(8), .PKT_LEN(1), .CNTW(4)) dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    logic [7:0] q_fifo  [$];
    logic [7:0] wr_pend [$];
    logic [8:0] exp_q   [$];
    logic       fifo_clr     = 1'b0;
    logic       fifo_empty_r = 1'b1;
    logic [7:0] fifo_data_r  = 8'h00;
    logic       flush_r      = 1'b0;
    logic       m_ready_r    = 1'b0;
    int         reads_served = 0;
    int         exp_idx      = 0;
    int         n_vec        = 0;
    int         n_miss       = 0;
    int         n_pops       = 0;

    logic       fifo_empty2 = 1'b1;
    logic [7:0] fifo_data2  = 8'h00;
    logic [7:0] src2        = 8'h01;
    logic       m_ready2    = 1'b0;

    assign bus1.fifo_empty = fifo_empty_r;
    assign bus1.fifo_data  = fifo_data_r;
    assign bus1.flush      = flush_r;
    assign bus1.m_ready    = m_ready_r;
    assign bus2.fifo_empty = fifo_empty2;
    assign bus2.fifo_data  = fifo_data2;
    assign bus2.flush      = 1'b0;
    assign bus2.m_ready    = m_ready2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_pend.push_back(d);
        exp_q.push_back({(exp_idx == 15), d});
        exp_idx = (exp_idx + 1) % 16;
    endtask

    task automatic wait_pops(input int target, input string nm);
        int k = 0;
        while (n_pops < target && k < 300) begin
            @(posedge clk); #1; k++;
        end
        chk(nm, 32'(n_pops), 32'(target));
    endtask

    // BRAM FIFO model: registered read data, writes visible the cycle after they are queued.
    always @(posedge clk) begin
        if (fifo_clr) begin
            q_fifo.delete();
        end else begin
            if (bus1.fifo_r_en && !fifo_empty_r) begin
                fifo_data_r  <= q_fifo.pop_front();
                reads_served <= reads_served + 1;
            end
            while (wr_pend.size() > 0) q_fifo.push_back(wr_pend.pop_front());
        end
        fifo_empty_r <= (q_fifo.size() == 0);
    end

    always @(posedge clk) begin
        if (bus2.fifo_r_en && !fifo_empty2) begin
            fifo_data2 <= src2;
            src2       <= src2 + 8'd1;
        end
    end

    logic       stall_prev = 1'b0;
    logic       flush_prev = 1'b0;
    logic [8:0] held       = 9'h000;

    always @(negedge clk) begin
        logic [8:0] e;
        if (rstn) begin
            if (stall_prev && !flush_prev)
                chk("hold", 32'({bus1.m_valid, bus1.m_last, bus1.m_data}), 32'({1'b1, held}));
            if (bus1.m_valid && bus1.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL pop_unexpected: got %0h, required no word", bus1.m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_word", 32'({bus1.m_last, bus1.m_data}), 32'(e));
                end
                n_pops <= n_pops + 1;
            end
            stall_prev <= bus1.m_valid && !bus1.m_ready;
            held       <= {bus1.m_last, bus1.m_data};
            flush_prev <= bus1.flush;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    initial begin
        int k;
        int base;
        int cnt;
        int n2;

        // Reset with words sitting in the FIFO
        for (int i = 0; i < 5; i++) wr_pend.push_back(8'(8'hE0 + i));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_en",   32'(bus1.fifo_r_en), 32'd0);
        chk("rst_valid",  32'(bus1.m_valid), 32'd0);
        chk("rst_data",   32'(bus1.m_data), 32'd0);
        chk("rst_last",   32'(bus1.m_last), 32'd0);
        chk("rst_stat",   32'(bus1.stat_words), 32'd0);
        chk("rst_stat2",  32'(bus2.stat_words), 32'd0);
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Full-rate stream of 0x01..0x20
        m_ready_r = 1'b1;
        for (int i = 1; i <= 32; i++) push_word(8'(i));
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (fifo_empty_r && k < 10);
        chk("lat_r_en", 32'(bus1.fifo_r_en), 32'd1);
        k = 0;
        while (!bus1.m_valid && k < 10) begin
            @(posedge clk); #1; k++;
        end
        chk("lat_valid", 32'(k), 32'd2);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus1.m_valid) cnt++;
            @(posedge clk); #1;
        end
        chk("stream_rate", 32'(cnt), 32'd32);
        wait_pops(32, "stream_pops");
        @(posedge clk); #1;
        chk("stream_stat", 32'(bus1.stat_words), 32'd32);

        // Backpressure mid-stream
        for (int i = 8'h21; i <= 8'h30; i++) push_word(8'(i));
        wait_pops(37, "bp_pre");
        m_ready_r = 1'b0;
        base = reads_served;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_reads_le3", 32'((reads_served - base) <= 3), 32'd1);
        chk("bp_valid", 32'(bus1.m_valid), 32'd1);
        m_ready_r = 1'b1;
        wait_pops(48, "bp_drain");

        // Drain to empty, refill five cycles later
        for (int i = 1; i <= 3; i++) push_word(8'(i));
        wait_pops(51, "refill_pre");
        repeat (5) @(posedge clk);
        #1;
        chk("refill_gap", 32'(bus1.m_valid), 32'd0);
        push_word(8'h04);
        wait_pops(52, "refill_pop");

        // Flush with occ=2 and one read in flight
        m_ready_r = 1'b0;
        base = reads_served;
        for (int i = 0; i < 20; i++) push_word(8'(8'h40 + i));
        k = 0;
        while (reads_served < base + 3 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("flush_reads", 32'(reads_served - base), 32'd3);
        flush_r = 1'b1;
        repeat (3) void'(exp_q.pop_front());
        for (int i = 0; i < exp_q.size(); i++) exp_q[i][8] = ((i % 16) == 15);
        exp_idx = exp_q.size() % 16;
        @(posedge clk); #1;
        flush_r = 1'b0;
        chk("flush_valid", 32'(bus1.m_valid), 32'd0);
        chk("flush_stat", 32'(bus1.stat_words), 32'd52);
        m_ready_r = 1'b1;
        wait_pops(69, "flush_drain");
        @(posedge clk); #1;
        chk("flush_stat_end", 32'(bus1.stat_words), 32'd69);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // PKT_LEN=1, CNTW=4: every word is last, counter wraps
        fifo_empty2 = 1'b0;
        m_ready2    = 1'b1;
        n2 = 0;
        k  = 0;
        while (n2 < 17 && k < 200) begin
            @(negedge clk);
            k++;
            if (bus2.m_valid && bus2.m_ready) begin
                chk("p1_data", 32'(bus2.m_data), 32'(n2 + 1));
                chk("p1_last", 32'(bus2.m_last), 32'd1);
                n2++;
            end
        end
        chk("p1_pops", 32'(n2), 32'd17);
        @(posedge clk); #1;
        m_ready2    = 1'b0;
        fifo_empty2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_stat", 32'(bus2.stat_words), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
